// File: rtl/axis_tc.sv
// axis_tc: AXI-Stream egress traffic checker (sequence, tdest, latency stats).
// Optional tready backpressure LFSR enabled by AXIS_TC_BACKPRESSURE_EN.
module axis_tc #(
  parameter int COUNT_WIDTH = 32,
  parameter int TDEST = 0,
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH = 2,
  parameter int LAT_WIDTH = 64,
  parameter logic [15:0] READY_SEED = 16'hB5A3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [COUNT_WIDTH-1:0] num_packets,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  input  logic [15:0] ready_load,
  output logic done,
  output logic [COUNT_WIDTH-1:0] recv_packets [2**TID_WIDTH],
  output logic [COUNT_WIDTH-1:0] seq_errors,
  output logic [COUNT_WIDTH-1:0] dest_errors,
  output logic [LAT_WIDTH-1:0] lat_sum,
  output logic [LAT_WIDTH-1:0] lat_max,
  input  logic axis_in_tvalid,
  output logic axis_in_tready,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic axis_in_tlast,
  input  logic [TID_WIDTH-1:0] axis_in_tid,
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest
);
  localparam int HALF = TDATA_WIDTH / 2;
  localparam int NSRC = 2 ** TID_WIDTH;

  typedef enum logic {IDLE, RUNNING} state_t;

  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] recv_q [NSRC];
  logic [COUNT_WIDTH-1:0] recv_d [NSRC];
  logic [COUNT_WIDTH-1:0] exp_q [NSRC];
  logic [COUNT_WIDTH-1:0] exp_d [NSRC];
  logic [COUNT_WIDTH-1:0] seq_err_q, seq_err_d;
  logic [COUNT_WIDTH-1:0] dest_err_q, dest_err_d;
  logic [LAT_WIDTH-1:0] lat_sum_q, lat_sum_d;
  logic [LAT_WIDTH-1:0] lat_max_q, lat_max_d;

  logic bp_ok;
  logic unused_w;

`ifdef AXIS_TC_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              ~(lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3])};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= READY_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign bp_ok = lfsr_q < ready_load;
  assign unused_w = ^{axis_in_tlast, axis_in_tdata};
`else
  assign bp_ok = 1'b1;
  assign unused_w = ^{axis_in_tlast, axis_in_tdata, ready_load, READY_SEED};
`endif

  logic [COUNT_WIDTH-1:0] seq;
  logic [HALF-1:0] diff;
  logic [LAT_WIDTH-1:0] lat;
  logic [LAT_WIDTH:0] sum_ext;
  logic hs;

  assign seq = axis_in_tdata[COUNT_WIDTH-1:0];
  assign diff = ticks - axis_in_tdata[TDATA_WIDTH-1:HALF];
  assign lat = LAT_WIDTH'(diff);
  assign sum_ext = {1'b0, lat_sum_q} + {1'b0, lat};

  // tready never looks at tvalid
  assign axis_in_tready = (state_q == RUNNING) &&
                          (total_q < num_packets) && bp_ok;
  assign hs = axis_in_tvalid && axis_in_tready;

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    recv_d = recv_q;
    exp_d = exp_q;
    seq_err_d = seq_err_q;
    dest_err_d = dest_err_q;
    lat_sum_d = lat_sum_q;
    lat_max_d = lat_max_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUNNING;
          total_d = '0;
          for (int i = 0; i < NSRC; i++) begin
            recv_d[i] = '0;
            exp_d[i] = '0;
          end
          seq_err_d = '0;
          dest_err_d = '0;
          lat_sum_d = '0;
          lat_max_d = '0;
        end
      end
      RUNNING: begin
        if (total_q >= num_packets) state_d = IDLE;
        if (hs) begin
          total_d = total_q + 1'b1;
          recv_d[axis_in_tid] = recv_q[axis_in_tid] + 1'b1;
          if (seq != exp_q[axis_in_tid])
            seq_err_d = seq_err_q + 1'b1;
          exp_d[axis_in_tid] = seq + 1'b1;
          if (axis_in_tdest != TDEST_WIDTH'(TDEST))
            dest_err_d = dest_err_q + 1'b1;
          lat_sum_d = sum_ext[LAT_WIDTH] ? '1 : sum_ext[LAT_WIDTH-1:0];
          if (lat > lat_max_q) lat_max_d = lat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      total_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        recv_q[i] <= '0;
        exp_q[i] <= '0;
      end
      seq_err_q <= '0;
      dest_err_q <= '0;
      lat_sum_q <= '0;
      lat_max_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      recv_q <= recv_d;
      exp_q <= exp_d;
      seq_err_q <= seq_err_d;
      dest_err_q <= dest_err_d;
      lat_sum_q <= lat_sum_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign done = (state_q == IDLE);
  assign recv_packets = recv_q;
  assign seq_errors = seq_err_q;
  assign dest_errors = dest_err_q;
  assign lat_sum = lat_sum_q;
  assign lat_max = lat_max_q;
endmodule
